dbg_probe_mux: RTL and testbench

- Parametrised debug-output block that drives the board's debug pin bank and LED row from a set of wide core debug channels (PC, SP, AF, BC, DE, HL, opcode, stage, ...).
- Slices each CH_W-bit channel into OUT_W-bit pieces.
- Modes: live select, timed auto-scan, and event-triggered snapshot capture.
- Sits in the top level between main's debug bus and the physical pins; replaces hard-wired pin assignments.

---
 rtl/dbg_probe_pkg.sv | 16 +
 rtl/dbg_probe_dwell.sv | 27 ++
 rtl/dbg_probe_mux.sv | 106 ++++++++++
 tb/tb_dbg_probe_mux.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_probe_pkg.sv
// Shared definitions for the debug probe mux: mode encoding and slice offset helper.
package dbg_probe_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE    = 2'b00,
    MODE_SCAN    = 2'b01,
    MODE_CAPTURE = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  // Flat slice index -> LSB position inside the packed channel bus.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned out_w);
    return idx * out_w;
  endfunction

endpackage

// File: rtl/dbg_probe_dwell.sv
// Free-running dwell counter with enable, synchronous clear and a wrap pulse on the last count.
module dbg_probe_dwell #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign wrap = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dbg_probe_mux.sv
// Debug pin/LED mux: live select, timed auto-scan and trig-edge snapshot capture of wide debug channels.
// Optional macro DBG_PROBE_HALT_FREEZE_EN: halted suppresses scan advance and captures.
module dbg_probe_mux
  import dbg_probe_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CH_W   = 16,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned DWELL  = 4194304,
  parameter int unsigned SEL_W  = $clog2(NUM_CH * CH_W / OUT_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     trig,
  input  logic                     halted,
  output logic [OUT_W-1:0]         pin_out,
  output logic [SEL_W-1:0]         cur_idx,
  output logic                     cap_valid,
  output logic [15:0]              cap_count,
  output logic                     scan_tick
);

  localparam int unsigned NSLICE = CH_W / OUT_W;
  localparam int unsigned TOTAL  = NUM_CH * NSLICE;
  localparam int unsigned OFF_W  = $clog2(NUM_CH * CH_W);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(TOTAL - 1);

  mode_e                   md;
  logic                    trig_q;
  logic                    trig_edge;
  logic                    freeze;
  logic                    cap_en;
  logic                    wrap;
  logic [SEL_W-1:0]        sel_c;
  logic [SEL_W-1:0]        next_idx;
  logic [OFF_W-1:0]        off;
  logic [NUM_CH*CH_W-1:0]  snap;
  logic [OUT_W-1:0]        live_slice;
  logic [OUT_W-1:0]        snap_slice;

  assign md = mode_e'(mode);

`ifdef DBG_PROBE_HALT_FREEZE_EN
  assign freeze = halted;
`else
  logic unused_halted;
  assign unused_halted = halted;
  assign freeze        = 1'b0;
`endif

  assign trig_edge = trig && !trig_q;
  assign cap_en    = trig_edge && (md == MODE_CAPTURE || md == MODE_HOLD) && !freeze;

  // Clearing outside SCAN (HOLD included) makes every SCAN entry start a fresh dwell period.
  dbg_probe_dwell #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (md == MODE_SCAN && !freeze),
    .clr  (md != MODE_SCAN),
    .wrap (wrap)
  );

  always_comb begin
    sel_c    = (32'(sel) >= TOTAL) ? LAST_IDX : sel;
    next_idx = cur_idx;
    case (md)
      MODE_LIVE, MODE_CAPTURE: next_idx = sel_c;
      MODE_SCAN: if (wrap) next_idx = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
      default: next_idx = cur_idx;
    endcase
    off        = OFF_W'(slice_lsb(32'(next_idx), OUT_W));
    live_slice = ch_data[off +: OUT_W];
    snap_slice = snap[off +: OUT_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_out   <= '0;
      cur_idx   <= '0;
      cap_valid <= 1'b0;
      cap_count <= '0;
      scan_tick <= 1'b0;
      trig_q    <= 1'b0;
      snap      <= '0;
    end else begin
      trig_q    <= trig;
      scan_tick <= wrap;
      if (md != MODE_HOLD) begin
        cur_idx <= next_idx;
        // Uses the pre-edge snapshot, so a same-cycle capture shows up one edge later.
        pin_out <= (md == MODE_CAPTURE && cap_valid) ? snap_slice : live_slice;
      end
      if (cap_en) begin
        snap      <= ch_data;
        cap_valid <= 1'b1;
        if (cap_count != '1) cap_count <= cap_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbg_probe_mux.sv
// Self-checking bench for dbg_probe_mux: directed vector table, multi-cycle sequences and random stimulus vs. a reference model.
module tb_dbg_probe_mux;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 16;
  localparam int OUT_W  = 8;
  localparam int DWELL  = 4;
  localparam int SEL_W  = 5;
  localparam int TOTAL  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_CH*CH_W-1:0] ch_data;
  logic [1:0]             mode;
  logic [SEL_W-1:0]       sel;
  logic                   trig;
  logic                   halted;
  logic [OUT_W-1:0]       pin_out;
  logic [SEL_W-1:0]       cur_idx;
  logic                   cap_valid;
  logic [15:0]            cap_count;
  logic                   scan_tick;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0]             m_pin;
  int                     m_idx;
  logic                   m_valid;
  int                     m_count;
  logic                   m_tick;
  logic [NUM_CH*CH_W-1:0] m_snap;
  logic                   m_prev;
  int                     m_age;

`ifdef DBG_PROBE_HALT_FREEZE_EN
  localparam bit HALT_FREEZE = 1'b1;
`else
  localparam bit HALT_FREEZE = 1'b0;
`endif

  always #5 clk = ~clk;

  dbg_probe_mux #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W),
    .OUT_W (OUT_W),
    .DWELL (DWELL),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_data  (ch_data),
    .mode     (mode),
    .sel      (sel),
    .trig     (trig),
    .halted   (halted),
    .pin_out  (pin_out),
    .cur_idx  (cur_idx),
    .cap_valid(cap_valid),
    .cap_count(cap_count),
    .scan_tick(scan_tick)
  );

  typedef struct {
    logic [1:0] mode;
    logic [4:0] sel;
    logic [7:0] pin;
    logic [4:0] idx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] slice_of(input logic [NUM_CH*CH_W-1:0] d, input int idx);
    logic [15:0] w;
    w = d[(idx / 2) * 16 +: 16];
    return (idx % 2) ? w[15:8] : w[7:0];
  endfunction

  function automatic int clamp(input int s);
    return (s >= TOTAL) ? TOTAL - 1 : s;
  endfunction

  task automatic model_reset();
    m_pin = 0; m_idx = 0; m_valid = 0; m_count = 0; m_tick = 0;
    m_snap = '0; m_prev = 0; m_age = 0;
  endtask

  task automatic model_edge();
    logic edge_now, frozen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edge_now = trig && !m_prev;
    m_prev   = trig;
    frozen   = HALT_FREEZE && halted;
    m_tick   = 0;
    case (mode)
      2'b00: begin
        m_age = 0; m_idx = clamp(int'(sel)); m_pin = slice_of(ch_data, m_idx);
      end
      2'b01: begin
        if (!frozen) begin
          m_age++;
          if (m_age == DWELL) begin
            m_age = 0; m_idx = (m_idx + 1) % TOTAL; m_tick = 1;
          end
        end
        m_pin = slice_of(ch_data, m_idx);
      end
      2'b10: begin
        m_age = 0; m_idx = clamp(int'(sel));
        m_pin = m_valid ? slice_of(m_snap, m_idx) : slice_of(ch_data, m_idx);
      end
      default: m_age = 0;
    endcase
    if (edge_now && mode[1] && !frozen) begin
      m_snap = ch_data; m_valid = 1;
      if (m_count < 65535) m_count++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pin_out",   32'(pin_out),   32'(m_pin));
    check("cur_idx",   32'(cur_idx),   32'(m_idx));
    check("cap_valid", 32'(cap_valid), 32'(m_valid));
    check("cap_count", 32'(cap_count), 32'(m_count));
    check("scan_tick", 32'(scan_tick), 32'(m_tick));
  endtask

  vec_t tbl[4];
  int   ticks;
  int   tick_idx[$];

  initial begin
    rst_n = 0; ch_data = '0; mode = 2'b00; sel = '0; trig = 0; halted = 0;
    model_reset();

    // reset held 3 cycles
    repeat (3) step();
    for (int k = 0; k < NUM_CH; k++) ch_data[k*16 +: 16] = 16'(16'h1111 * k);
    ch_data[2*16 +: 16] = 16'hBEEF;
    rst_n = 1;
    #1 check("pin_after_release", 32'(pin_out), 32'h0);

    // LIVE vector table
    tbl[0] = '{mode: 2'b00, sel: 5'd5,  pin: 8'hBE, idx: 5'd5};
    tbl[1] = '{mode: 2'b00, sel: 5'd4,  pin: 8'hEF, idx: 5'd4};
    tbl[2] = '{mode: 2'b00, sel: 5'd20, pin: 8'h77, idx: 5'd15};
    tbl[3] = '{mode: 2'b00, sel: 5'd7,  pin: 8'h33, idx: 5'd7};
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel;
      step();
      check("tbl_pin", 32'(pin_out), 32'(tbl[i].pin));
      check("tbl_idx", 32'(cur_idx), 32'(tbl[i].idx));
    end

    // SCAN from index 14
    mode = 2'b00; sel = 5'd14; step();
    mode = 2'b01; ticks = 0; tick_idx.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (scan_tick) begin
        ticks++; tick_idx.push_back(int'(cur_idx));
        check("scan_tick_phase", 32'(i % DWELL), 32'(DWELL - 1));
      end
    end
    check("scan_tick_count", 32'(ticks), 32'd3);
    if (tick_idx.size() == 3) begin
      check("scan_seq0", 32'(tick_idx[0]), 32'd15);
      check("scan_seq1", 32'(tick_idx[1]), 32'd0);
      check("scan_seq2", 32'(tick_idx[2]), 32'd1);
    end

    // CAPTURE: trig held high 10 cycles counts once
    rst_n = 0; step(); rst_n = 1;
    ch_data[15:0] = 16'h0150; mode = 2'b10; sel = '0; trig = 0; step();
    trig = 1;
    repeat (10) step();
    check("cap_count_held", 32'(cap_count), 32'd1);
    ch_data[15:0] = 16'h0200; trig = 0;
    step(); step();
    check("cap_pin", 32'(pin_out), 32'h50);
    check("cap_valid_set", 32'(cap_valid), 32'd1);
    check("cap_count_one", 32'(cap_count), 32'd1);

    // HOLD: frozen view while captures continue
    mode = 2'b11; step();
    ch_data[15:0] = 16'h1234; ch_data[127:16] = {$urandom, $urandom, $urandom, 16'($urandom)};
    trig = 1; step(); trig = 0; step(); trig = 1; step(); trig = 0; step();
    check("hold_pin", 32'(pin_out), 32'h50);
    check("hold_count", 32'(cap_count), 32'd3);
    mode = 2'b10; sel = '0; ch_data[15:0] = 16'hFFFF; step();
    check("hold_to_capture_pin", 32'(pin_out), 32'h34);
    check("cap_valid_kept", 32'(cap_valid), 32'd1);

    // halted during SCAN
    mode = 2'b00; sel = 5'd3; step();
    halted = 1; mode = 2'b01; ticks = 0;
    repeat (20) begin
      step();
      if (scan_tick) ticks++;
    end
    check("halt_ticks", 32'(ticks), HALT_FREEZE ? 32'd0 : 32'd5);
    check("halt_idx", 32'(cur_idx), HALT_FREEZE ? 32'd3 : 32'd8);
    halted = 0;

    // random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      sel    = 5'($urandom_range(0, 31));
      trig   = 1'($urandom_range(0, 1));
      halted = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) ch_data = {$urandom, $urandom, $urandom, $urandom};
      rst_n  = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
